// File: rtl/mnacidpro_pkg.sv
// rtl/mnacidpro_pkg.sv - shared states, valve map and pump phases for the mnacidpro sequencer
package mnacidpro_pkg;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_BEAD_LOAD = 4'd1,
      ST_CELL_LOAD = 4'd2,
      ST_LYSIS     = 4'd3,
      ST_TRAP      = 4'd4,
      ST_WASH      = 4'd5,
      ST_ELUTE     = 4'd6,
      ST_COLLECT   = 4'd7,
      ST_DONE      = 4'd8
   } state_e;

   localparam int NUM_VALVES = 11;
   typedef logic [NUM_VALVES-1:0] valve_t;

   localparam int V_LYSIS     = 0;
   localparam int V_WASH      = 1;
   localparam int V_ELUTE     = 2;
   localparam int V_DEAD_END  = 3;
   localparam int V_VERTICAL  = 4;
   localparam int V_HORIZ     = 5;
   localparam int V_WASTE     = 6;
   localparam int V_BEAD      = 7;
   localparam int V_LOOP_EXIT = 8;
   localparam int V_BEAD_TRAP = 9;
   localparam int V_COLLECT   = 10;

   localparam logic [2:0] PUMP_OFF = 3'b111;
   localparam logic [2:0] PUMP_PH0 = 3'b011;
   localparam logic [2:0] PUMP_PH1 = 3'b101;
   localparam logic [2:0] PUMP_PH2 = 3'b110;

   // A set bit means the valve is open (unpressurized) in that state.
   function automatic valve_t open_mask(state_e s);
      valve_t m;
      m = '0;
      case (s)
         ST_BEAD_LOAD: begin m[V_BEAD] = 1'b1;  m[V_VERTICAL] = 1'b1; end
         ST_CELL_LOAD: begin m[V_HORIZ] = 1'b1; m[V_VERTICAL] = 1'b1; end
         ST_LYSIS:     begin m[V_LYSIS] = 1'b1; m[V_HORIZ] = 1'b1; end
         ST_TRAP:      begin m[V_LOOP_EXIT] = 1'b1; m[V_WASTE] = 1'b1; end
         ST_WASH:      begin m[V_WASH] = 1'b1; m[V_LOOP_EXIT] = 1'b1; m[V_WASTE] = 1'b1; end
         ST_ELUTE:     begin m[V_ELUTE] = 1'b1; m[V_LOOP_EXIT] = 1'b1; m[V_DEAD_END] = 1'b1; end
         ST_COLLECT:   begin m[V_COLLECT] = 1'b1; m[V_LOOP_EXIT] = 1'b1; end
         default:      m = '0;
      endcase
      return m;
   endfunction

   function automatic logic is_pumping(state_e s);
      return (s >= ST_BEAD_LOAD) && (s <= ST_COLLECT);
   endfunction

   function automatic logic [2:0] pump_phase(logic [1:0] ph);
      case (ph)
         2'd0:    return PUMP_PH0;
         2'd1:    return PUMP_PH1;
         default: return PUMP_PH2;
      endcase
   endfunction

endpackage

// File: rtl/peristaltic_pump_gen.sv
// rtl/peristaltic_pump_gen.sv - 3-phase peristaltic pump pattern with per-stroke pulse
module peristaltic_pump_gen
   import mnacidpro_pkg::*;
#(
   parameter int PUMP_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       restart,
   output logic [2:0] pump,
   output logic       stroke_done
);

   localparam int DW = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;

   logic [DW-1:0] div_q;
   logic [1:0]    phase_q;
   logic [1:0]    phase_nx;
   logic          run_q;
   logic [2:0]    pump_q;
   logic          div_wrap;

   assign div_wrap    = (div_q == DW'(PUMP_DIV - 1));
   assign phase_nx    = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
   assign stroke_done = run_q && div_wrap && (phase_q == 2'd2);
   assign pump        = pump_q;

   // en/restart describe the coming cycle, so pump_q lands aligned with the new state.
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         div_q   <= '0;
         phase_q <= 2'd0;
         run_q   <= 1'b0;
         pump_q  <= PUMP_OFF;
      end else if (restart || !run_q) begin
         div_q   <= '0;
         phase_q <= 2'd0;
         run_q   <= 1'b1;
         pump_q  <= PUMP_PH0;
      end else if (div_wrap) begin
         div_q   <= '0;
         phase_q <= phase_nx;
         pump_q  <= pump_phase(phase_nx);
      end else begin
         div_q   <= div_q + DW'(1);
      end
   end

endmodule

// File: rtl/mnacidpro_ctrl_seq.sv
// rtl/mnacidpro_ctrl_seq.sv - protocol sequencer driving the mnacidpro control-layer valves and pump
module mnacidpro_ctrl_seq
   import mnacidpro_pkg::*;
#(
   parameter int SIZE            = 4,
   parameter int PUMP_DIV        = 4,
   parameter int LOAD_STROKES    = 8,
   parameter int LYSIS_STROKES   = 16,
   parameter int TRAP_STROKES    = 4,
   parameter int WASH_STROKES    = 8,
   parameter int ELUTE_STROKES   = 4,
   parameter int COLLECT_STROKES = 2,
   localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [3:0]       state,
   output logic [IDX_W-1:0] collect_idx,
   output logic             lysis_ctrl,
   output logic             wash_ctrl,
   output logic             elute_ctrl,
   output logic             dead_end_ctrl,
   output logic             vertical_ctrl,
   output logic             horiz_ctrl,
   output logic             waste_ctrl,
   output logic             bead_ctrl,
   output logic             loop_exit_ctrl,
   output logic             bead_trap_ctrl,
   output logic             collect_ctrl,
   output logic [2:0]       pump
);

   state_e           state_q, state_d;
   logic [15:0]      stroke_q, stroke_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             abort_d;
   logic             busy_q, done_q, aborted_q;
   valve_t           valve_q;
   logic             stroke_done;

   function automatic logic [15:0] stroke_limit(state_e s);
      case (s)
         ST_BEAD_LOAD, ST_CELL_LOAD: return 16'(LOAD_STROKES);
         ST_LYSIS:                   return 16'(LYSIS_STROKES);
         ST_TRAP:                    return 16'(TRAP_STROKES);
         ST_WASH:                    return 16'(WASH_STROKES);
         ST_ELUTE:                   return 16'(ELUTE_STROKES);
         ST_COLLECT:                 return 16'(COLLECT_STROKES);
         default:                    return 16'd1;
      endcase
   endfunction

   always_comb begin
      state_d  = state_q;
      stroke_d = stroke_q;
      idx_d    = idx_q;
      abort_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            stroke_d = '0;
            if (start) state_d = ST_BEAD_LOAD;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            idx_d   = '0;
            abort_d = abort;
         end
         ST_BEAD_LOAD, ST_CELL_LOAD, ST_LYSIS, ST_TRAP, ST_WASH, ST_ELUTE, ST_COLLECT: begin
            if (abort) begin
               state_d  = ST_IDLE;
               stroke_d = '0;
               idx_d    = '0;
               abort_d  = 1'b1;
            end else if (stroke_done) begin
               if (stroke_q == stroke_limit(state_q) - 16'd1) begin
                  stroke_d = '0;
                  if (state_q != ST_COLLECT) begin
                     state_d = state_e'(state_q + 4'd1);
                  end else if (idx_q == IDX_W'(SIZE - 1)) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_ELUTE;
                     idx_d   = idx_q + IDX_W'(1);
                  end
               end else begin
                  stroke_d = stroke_q + 16'd1;
               end
            end
         end
         default: begin
            state_d  = ST_IDLE;
            stroke_d = '0;
            idx_d    = '0;
         end
      endcase
   end

   // Outputs are registered from the next state so valves flip on the state-change edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         stroke_q  <= '0;
         idx_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         valve_q   <= '1;
      end else begin
         state_q   <= state_d;
         stroke_q  <= stroke_d;
         idx_q     <= idx_d;
         busy_q    <= (state_d != ST_IDLE);
         done_q    <= (state_d == ST_DONE);
         aborted_q <= abort_d;
         valve_q   <= ~open_mask(state_d);
      end
   end

   peristaltic_pump_gen #(
      .PUMP_DIV(PUMP_DIV)
   ) u_pump (
      .clk        (clk),
      .rst        (rst),
      .en         (is_pumping(state_d)),
      .restart    (state_d != state_q),
      .pump       (pump),
      .stroke_done(stroke_done)
   );

   assign state          = state_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign aborted        = aborted_q;
   assign collect_idx    = idx_q;
   assign lysis_ctrl     = valve_q[V_LYSIS];
   assign wash_ctrl      = valve_q[V_WASH];
   assign elute_ctrl     = valve_q[V_ELUTE];
   assign dead_end_ctrl  = valve_q[V_DEAD_END];
   assign vertical_ctrl  = valve_q[V_VERTICAL];
   assign horiz_ctrl     = valve_q[V_HORIZ];
   assign waste_ctrl     = valve_q[V_WASTE];
   assign bead_ctrl      = valve_q[V_BEAD];
   assign loop_exit_ctrl = valve_q[V_LOOP_EXIT];
   assign bead_trap_ctrl = valve_q[V_BEAD_TRAP];
   assign collect_ctrl   = valve_q[V_COLLECT];

endmodule

// File: tb/tb_mnacidpro_ctrl_seq.sv
// tb/tb_mnacidpro_ctrl_seq.sv - scoreboard bench for mnacidpro_ctrl_seq against a run-schedule model
module tb_mnacidpro_ctrl_seq;

   localparam int SIZE     = 3;
   localparam int DIV      = 2;
   localparam int LOAD_S   = 2;
   localparam int LYSIS_S  = 3;
   localparam int TRAP_S   = 1;
   localparam int WASH_S   = 2;
   localparam int ELUTE_S  = 1;
   localparam int COLL_S   = 2;
   localparam int IDX_W    = (SIZE > 1) ? $clog2(SIZE) : 1;

   // Bench-local valve bit order: {lysis,wash,elute,dead_end,vertical,horiz,waste,bead,loop_exit,bead_trap,collect}
   localparam int B_LYSIS = 10, B_WASH = 9, B_ELUTE = 8, B_DEAD = 7, B_VERT = 6, B_HORIZ = 5;
   localparam int B_WASTE = 4, B_BEAD = 3, B_LOOP = 2, B_TRAP = 1, B_COLL = 0;

   typedef struct packed {
      logic [3:0]       st;
      logic             busy;
      logic             done;
      logic             aborted;
      logic [IDX_W-1:0] idx;
      logic [10:0]      valves;
      logic [2:0]       pump;
   } exp_t;

   logic clk;
   logic rst, start, abort;
   logic busy, done, aborted;
   logic [3:0] state;
   logic [IDX_W-1:0] collect_idx;
   logic lysis_ctrl, wash_ctrl, elute_ctrl, dead_end_ctrl, vertical_ctrl, horiz_ctrl;
   logic waste_ctrl, bead_ctrl, loop_exit_ctrl, bead_trap_ctrl, collect_ctrl;
   logic [2:0] pump;

   mnacidpro_ctrl_seq #(
      .SIZE(SIZE), .PUMP_DIV(DIV), .LOAD_STROKES(LOAD_S), .LYSIS_STROKES(LYSIS_S),
      .TRAP_STROKES(TRAP_S), .WASH_STROKES(WASH_S), .ELUTE_STROKES(ELUTE_S),
      .COLLECT_STROKES(COLL_S)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .busy(busy), .done(done), .aborted(aborted), .state(state), .collect_idx(collect_idx),
      .lysis_ctrl(lysis_ctrl), .wash_ctrl(wash_ctrl), .elute_ctrl(elute_ctrl),
      .dead_end_ctrl(dead_end_ctrl), .vertical_ctrl(vertical_ctrl), .horiz_ctrl(horiz_ctrl),
      .waste_ctrl(waste_ctrl), .bead_ctrl(bead_ctrl), .loop_exit_ctrl(loop_exit_ctrl),
      .bead_trap_ctrl(bead_trap_ctrl), .collect_ctrl(collect_ctrl), .pump(pump)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;
   int cyc_n  = 0;
   exp_t exp_q[$];

   // Run schedule: one entry per protocol segment.
   int seg_st[$];
   int seg_idx[$];
   int seg_len[$];
   int run_len = 0;
   bit m_run = 1'b0;
   int m_pos = 0;

   function automatic logic [10:0] open_set(int st);
      logic [10:0] m;
      m = '0;
      case (st)
         1: begin m[B_BEAD] = 1; m[B_VERT] = 1; end
         2: begin m[B_HORIZ] = 1; m[B_VERT] = 1; end
         3: begin m[B_LYSIS] = 1; m[B_HORIZ] = 1; end
         4: begin m[B_LOOP] = 1; m[B_WASTE] = 1; end
         5: begin m[B_WASH] = 1; m[B_LOOP] = 1; m[B_WASTE] = 1; end
         6: begin m[B_ELUTE] = 1; m[B_LOOP] = 1; m[B_DEAD] = 1; end
         7: begin m[B_COLL] = 1; m[B_LOOP] = 1; end
         default: m = '0;
      endcase
      return m;
   endfunction

   function automatic void add_seg(int st, int idx, int len);
      seg_st.push_back(st);
      seg_idx.push_back(idx);
      seg_len.push_back(len);
      run_len += len;
   endfunction

   function automatic int seg_of(int pos, output int off);
      int k = 0;
      off = pos;
      while (k < seg_len.size() - 1 && off >= seg_len[k]) begin
         off -= seg_len[k];
         k++;
      end
      return k;
   endfunction

   function automatic exp_t idle_exp(bit ab);
      exp_t e;
      e.st = 4'd0; e.busy = 0; e.done = 0; e.aborted = ab; e.idx = '0;
      e.valves = '1; e.pump = 3'b111;
      return e;
   endfunction

   function automatic exp_t run_exp(int pos);
      exp_t e;
      int off, k;
      logic [2:0] pat [3];
      pat[0] = 3'b011; pat[1] = 3'b101; pat[2] = 3'b110;
      k = seg_of(pos, off);
      e.st      = 4'(seg_st[k]);
      e.busy    = 1;
      e.done    = (seg_st[k] == 8);
      e.aborted = 0;
      e.idx     = IDX_W'(seg_idx[k]);
      e.valves  = ~open_set(seg_st[k]);
      e.pump    = (seg_st[k] == 8) ? 3'b111 : pat[(off / DIV) % 3];
      return e;
   endfunction

   function automatic int cur_state();
      int off;
      if (!m_run) return 0;
      return seg_st[seg_of(m_pos, off)];
   endfunction

   function automatic int cur_idx();
      int off;
      if (!m_run) return 0;
      return seg_idx[seg_of(m_pos, off)];
   endfunction

   function automatic int cur_off();
      int off, k;
      k = seg_of(m_pos, off);
      return (k >= 0) ? off : 0;
   endfunction

   task automatic tick(input bit s, input bit a, input bit r);
      exp_t e;
      start = s; abort = a; rst = r;
      if (r) begin
         m_run = 0;
         e = idle_exp(0);
      end else if (!m_run) begin
         if (s) begin
            m_run = 1; m_pos = 0;
            e = run_exp(0);
         end else begin
            e = idle_exp(0);
         end
      end else if (a) begin
         m_run = 0;
         e = idle_exp(1);
      end else begin
         m_pos++;
         if (m_pos >= run_len) begin
            m_run = 0;
            e = idle_exp(0);
         end else begin
            e = run_exp(m_pos);
         end
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic run_until(input int st, input int idx, input int off);
      int n = 0;
      while (!(m_run && cur_state() == st && cur_idx() == idx && (off < 0 || cur_off() == off))
             && n < 2000) begin
         tick(0, 0, 0);
         n++;
      end
      if (n >= 2000) begin
         checks++;
         $display("FAIL run_until: state %0d idx %0d never reached", st, idx);
      end
   endtask

   task automatic run_to_idle();
      int n = 0;
      while (m_run && n < 2000) begin
         tick(0, 0, 0);
         n++;
      end
      tick(0, 0, 0);
   endtask

   always @(negedge clk) begin
      exp_t e, a;
      cyc_n++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a.st = state; a.busy = busy; a.done = done; a.aborted = aborted; a.idx = collect_idx;
         a.valves = {lysis_ctrl, wash_ctrl, elute_ctrl, dead_end_ctrl, vertical_ctrl, horiz_ctrl,
                     waste_ctrl, bead_ctrl, loop_exit_ctrl, bead_trap_ctrl, collect_ctrl};
         a.pump = pump;
         checks++;
         if (a === e) passed++;
         else $display("FAIL outputs cycle %0d: got st=%0d busy=%b done=%b ab=%b idx=%0d valves=%b pump=%b, expected st=%0d busy=%b done=%b ab=%b idx=%0d valves=%b pump=%b",
                       cyc_n, a.st, a.busy, a.done, a.aborted, a.idx, a.valves, a.pump,
                       e.st, e.busy, e.done, e.aborted, e.idx, e.valves, e.pump);
      end
   end

   initial begin
      start = 0; abort = 0; rst = 1;
      add_seg(1, 0, LOAD_S * 3 * DIV);
      add_seg(2, 0, LOAD_S * 3 * DIV);
      add_seg(3, 0, LYSIS_S * 3 * DIV);
      add_seg(4, 0, TRAP_S * 3 * DIV);
      add_seg(5, 0, WASH_S * 3 * DIV);
      for (int r = 0; r < SIZE; r++) begin
         add_seg(6, r, ELUTE_S * 3 * DIV);
         add_seg(7, r, COLL_S * 3 * DIV);
      end
      add_seg(8, SIZE - 1, 1);

      repeat (3) tick(0, 0, 1);
      for (int i = 0; i < 10; i++) tick(0, 1'($urandom_range(0, 1)), 0);

      tick(1, 0, 0);
      run_to_idle();

      tick(1, 0, 0);
      run_until(3, 0, 3 * DIV + 1);
      tick(0, 1, 0);
      repeat (3) tick(0, 0, 0);
      tick(1, 1, 0);
      run_to_idle();

      tick(1, 0, 0);
      run_until(5, 0, -1);
      tick(1, 0, 0);
      tick(1, 0, 0);
      run_until(6, 1, -1);
      tick(0, 0, 1);
      repeat (5) tick(0, 0, 0);

      for (int i = 0; i < 800; i++) begin
         tick(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 59) == 0),
              1'($urandom_range(0, 199) == 0));
      end
      tick(0, 0, 0);
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         checks++;
         $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/mnacidpro_ctrl_seq.md
# mnacidpro_ctrl_seq

Off-chip controller sequencer that drives the control-layer pads of the `mnacidpro_pads` nucleic-acid purification chip. It steps the chip through one full protocol run: bead load, cell load, lysis, bead trap, wash, then SIZE elute/collect rounds. It also generates the 3-phase peristaltic pump pattern. It sits in the host FPGA, and its valve outputs feed the pneumatic solenoid drivers that pressurize the chip's `ctrl` inputs.

## Interface
Parameters:
- `SIZE`, 4: number of elute/collect rounds (one per collect outlet).
- `PUMP_DIV`, 4: clock cycles each pump phase is held (≥1).
- `LOAD_STROKES`, 8: pump strokes for BEAD_LOAD and for CELL_LOAD.
- `LYSIS_STROKES`, 16: strokes for LYSIS.
- `TRAP_STROKES`, 4: strokes for TRAP.
- `WASH_STROKES`, 8: strokes for WASH.
- `ELUTE_STROKES`, 4: strokes for ELUTE.
- `COLLECT_STROKES`, 2: strokes for COLLECT.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a run; sampled only in IDLE.
- `abort` in 1: terminate the run.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a run completes normally.
- `aborted` out 1: one-cycle pulse when a run is aborted.
- `state` out 4: current state encoding.
- `collect_idx` out `$clog2(SIZE)` (min 1): current collect round.
- `lysis_ctrl`, `wash_ctrl`, `elute_ctrl`, `dead_end_ctrl`, `vertical_ctrl`, `horiz_ctrl`, `waste_ctrl`, `bead_ctrl`, `loop_exit_ctrl`, `bead_trap_ctrl`, `collect_ctrl` out 1 each: valve drives; 1 = pressurized = valve closed.
- `pump` out 3: pump valve drives, same polarity.

## Operation
- States, with encodings: IDLE=0, BEAD_LOAD=1, CELL_LOAD=2, LYSIS=3, TRAP=4, WASH=5, ELUTE=6, COLLECT=7, DONE=8.
- Transition order: IDLE →(start) BEAD_LOAD → CELL_LOAD → LYSIS → TRAP → WASH → ELUTE → COLLECT.
  - From COLLECT: if `collect_idx`==SIZE-1, go to DONE. Otherwise go to ELUTE and increment `collect_idx`.
  - DONE → IDLE unconditionally.
- A pumping state (1–7) exits when its stroke count reaches its parameter.
- Valves open (driven 0) per state; every other valve is driven 1:
  - BEAD_LOAD: `bead_ctrl`, `vertical_ctrl`.
  - CELL_LOAD: `horiz_ctrl`, `vertical_ctrl`.
  - LYSIS: `lysis_ctrl`, `horiz_ctrl`.
  - TRAP: `loop_exit_ctrl`, `waste_ctrl`.
  - WASH: `wash_ctrl`, `loop_exit_ctrl`, `waste_ctrl`.
  - ELUTE: `elute_ctrl`, `loop_exit_ctrl`, `dead_end_ctrl`.
  - COLLECT: `collect_ctrl`, `loop_exit_ctrl`.
  - IDLE and DONE: all valves closed.
- `bead_trap_ctrl` stays 1 (closed) in every state.
- Pump behaviour:
  - In IDLE and DONE, `pump` = 3'b111.
  - In pumping states it cycles 3'b011 → 3'b101 → 3'b110, each value held `PUMP_DIV` cycles. One stroke is those three phases.
  - Every pumping state starts at phase 3'b011 with the divider and stroke counters cleared.
- `abort` in any non-IDLE state:
  - Next cycle is IDLE with all valves closed, `pump`=3'b111, and `collect_idx`=0.
  - `aborted` pulses in that cycle.
  - `abort` in IDLE is ignored.
- Priority: `rst` > `abort` > stroke-complete transition.
- `start` in a non-IDLE state is ignored. `start` and `abort` together in IDLE: the run starts.
- `collect_idx` is 0 from IDLE through the first COLLECT. It holds its final value through DONE and clears on entering IDLE.

## Timing
- All outputs are registered, and valve and pump outputs change only on the clock edge that changes state or phase.
- Reset values: state=IDLE, `busy`=0, `done`=0, `aborted`=0, `collect_idx`=0, all 11 valve outputs 1, `pump`=3'b111. Reset mid-run gives these values on the next cycle with no DONE.
- `start` sampled high at edge k: from cycle k+1, state=BEAD_LOAD, `busy`=1, and `pump`=3'b011.
- Each pumping state lasts exactly strokes×3×`PUMP_DIV` cycles. The next state's pattern appears in the cycle immediately after the last phase cycle, with no gap.
- DONE lasts exactly one cycle with `done`=1 and `busy`=1. IDLE follows.

## Structure
- Package `mnacidpro_pkg` contains:
  - the state enum;
  - the 11-bit valve vector with named index constants;
  - a function mapping state to its open-valve mask;
  - pump phase constants.
- Sub-module `peristaltic_pump_gen`:
  - inputs: `clk`, `rst`, `en`, `restart`;
  - parameter: `PUMP_DIV`;
  - outputs: `pump[2:0]` and a one-cycle `stroke_done` pulse.
- The top level holds the FSM, the per-state stroke counter, and `collect_idx`.

## Test plan
- Reset, then idle for 10 cycles → all valve outputs and `pump` = 1, `busy`=0, `state`=0.
- Full run with `PUMP_DIV`=2, all strokes=1, `SIZE`=2, `start` at edge 0:
  - each pumping state lasts 6 cycles;
  - ELUTE runs at cycles 31–36 and 43–48; COLLECT at 37–42 (`collect_idx`=0) and 49–54 (`collect_idx`=1);
  - `done`=1 only at cycle 55, and IDLE at 56.
- Pump pattern, `PUMP_DIV`=3 → in BEAD_LOAD, `pump` reads 011×3, 101×3, 110×3, repeating; the first cycle of CELL_LOAD reads 011.
- `abort` during the second stroke of LYSIS → next cycle IDLE, `aborted`=1, all valves 1, `done` never asserted. Restart with `start` → fresh run beginning at BEAD_LOAD.
- `start` pulsed during WASH, and `rst` asserted in ELUTE → `start` has no effect. After `rst`, all reset values hold and `collect_idx`=0.
- In each state, check the valve mask against the per-state open list, including `bead_trap_ctrl`=1 in every state.
